// File: rtl/trap_irq_ctrl.sv
// rtl/trap_irq_ctrl.sv - interrupt pending/priority logic and M/U trap-entry FSM
//
// Ports:
//   clk_in, reset_in    clock; synchronous active-high reset
//   irq_src, irq_en     raw interrupt lines and per-source enables
//   mstatus_mie         global Machine-mode interrupt enable
//   mtvec               trap vector base; [1:0]==01 selects vectored mode
//   exception_flag      synchronous exception taken this cycle
//   mret                MRET retiring this cycle
//   pend_clr(_idx)      software clear of one edge-pending bit
//   trap_ack            downstream accepts trap_req
//   trap_req            interrupt trap request (high while in REQ)
//   trap_cause, trap_pc latched cause word and handler address
//   mode                current privilege (3=M, 0=U)
//   pending             current pending vector
module trap_irq_ctrl #(
    parameter int                 NUM_SRC   = 16,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
    parameter bit                 HAS_U     = 1'b1,
    parameter int                 PC_SZ     = 32
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               mstatus_mie,
    input  logic [PC_SZ-1:0]   mtvec,
    input  logic               exception_flag,
    input  logic               mret,
    input  logic               pend_clr,
    input  logic [4:0]         pend_clr_idx,
    input  logic               trap_ack,
    output logic               trap_req,
    output logic [PC_SZ-1:0]   trap_cause,
    output logic [PC_SZ-1:0]   trap_pc,
    output logic [1:0]         mode,
    output logic [NUM_SRC-1:0] pending
);

    localparam logic [1:0] MODE_M = 2'b11;
    localparam logic [1:0] MODE_U = 2'b00;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] smp_q, smp_d;
    logic [NUM_SRC-1:0] smp_dly_q, smp_dly_d;
    logic [NUM_SRC-1:0] pend_edge_q, pend_edge_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         mpp_q, mpp_d;
    logic [PC_SZ-1:0]   trap_cause_q, trap_cause_d;
    logic [PC_SZ-1:0]   trap_pc_q, trap_pc_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr;
    logic [4:0]         sel;
    logic               gie;
    logic [PC_SZ-1:0]   base_pc;
    logic [PC_SZ-1:0]   vec_off;
    logic [PC_SZ-1:0]   sel_pc;
    logic [PC_SZ-1:0]   sel_cause;

    always_comb begin
        smp_d     = irq_src;
        smp_dly_d = smp_q;
        rise      = smp_q & ~smp_dly_q;

        // Level sources follow the sampled line; edge sources come from the latch.
        pend = (pend_edge_q & EDGE_MASK) | (smp_q & ~EDGE_MASK);
        elig = pend & irq_en;

        // Ascending scan so the highest eligible index is the one kept.
        sel = 5'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i]) sel = 5'(i);
        end

        gie = ((mode_q == MODE_M) ? mstatus_mie : 1'b1) && (state_q == ST_IDLE);

        base_pc      = {mtvec[PC_SZ-1:2], 2'b00};
        vec_off      = '0;
        vec_off[6:2] = sel;
        sel_pc       = (mtvec[1:0] == 2'b01) ? base_pc + vec_off : base_pc;

        sel_cause          = '0;
        sel_cause[PC_SZ-1] = 1'b1;
        sel_cause[4:0]     = sel;

        // Indices >= NUM_SRC never match a loop index, so they clear nothing.
        clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend_clr && pend_clr_idx == 5'(i)) clr[i] = 1'b1;
            if (state_q == ST_REQ && trap_ack && trap_cause_q[4:0] == 5'(i)) clr[i] = 1'b1;
        end
        // A new edge in the same cycle as a clear must survive.
        pend_edge_d = ((pend_edge_q & ~clr) | rise) & EDGE_MASK;

        state_d      = state_q;
        mode_d       = mode_q;
        mpp_d        = mpp_q;
        trap_cause_d = trap_cause_q;
        trap_pc_d    = trap_pc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (exception_flag) begin
                    state_d = ST_ACTIVE;
                    mpp_d   = mode_q;
                    mode_d  = MODE_M;
                end else if (mret) begin
                    mode_d = mpp_q;
                    mpp_d  = HAS_U ? MODE_U : MODE_M;
                end else if ((|elig) && gie) begin
                    state_d      = ST_REQ;
                    trap_cause_d = sel_cause;
                    trap_pc_d    = sel_pc;
                end
            end
            ST_REQ: begin
                if (trap_ack) begin
                    state_d = ST_ACTIVE;
                    mpp_d   = mode_q;
                    mode_d  = MODE_M;
                end
            end
            ST_ACTIVE: begin
                if (mret) begin
                    state_d = ST_IDLE;
                    mode_d  = mpp_q;
                    mpp_d   = HAS_U ? MODE_U : MODE_M;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!HAS_U) begin
            mode_d = MODE_M;
            mpp_d  = MODE_M;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            smp_q        <= '0;
            smp_dly_q    <= '0;
            pend_edge_q  <= '0;
            mode_q       <= MODE_M;
            mpp_q        <= MODE_M;
            trap_cause_q <= '0;
            trap_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            smp_q        <= smp_d;
            smp_dly_q    <= smp_dly_d;
            pend_edge_q  <= pend_edge_d;
            mode_q       <= mode_d;
            mpp_q        <= mpp_d;
            trap_cause_q <= trap_cause_d;
            trap_pc_q    <= trap_pc_d;
        end
    end

    assign trap_req   = (state_q == ST_REQ);
    assign trap_cause = trap_cause_q;
    assign trap_pc    = trap_pc_q;
    assign mode       = mode_q;
    assign pending    = pend;

endmodule

// File: tb/tb_trap_irq_ctrl.sv
// tb/tb_trap_irq_ctrl.sv - directed self-checking bench for trap_irq_ctrl
module tb_trap_irq_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [15:0] irq_src;
    logic [15:0] irq_en;
    logic        mstatus_mie;
    logic [31:0] mtvec;
    logic        exception_flag;
    logic        mret;
    logic        pend_clr;
    logic [4:0]  pend_clr_idx;
    logic        trap_ack;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [1:0]  mode;
    logic [15:0] pending;

    int n_cmp = 0;
    int n_err = 0;

    trap_irq_ctrl #(
        .NUM_SRC  (16),
        .EDGE_MASK(16'h0028),
        .HAS_U    (1'b1),
        .PC_SZ    (32)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .irq_src       (irq_src),
        .irq_en        (irq_en),
        .mstatus_mie   (mstatus_mie),
        .mtvec         (mtvec),
        .exception_flag(exception_flag),
        .mret          (mret),
        .pend_clr      (pend_clr),
        .pend_clr_idx  (pend_clr_idx),
        .trap_ack      (trap_ack),
        .trap_req      (trap_req),
        .trap_cause    (trap_cause),
        .trap_pc       (trap_pc),
        .mode          (mode),
        .pending       (pending)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset_in       = 1'b1;
        irq_src        = '0;
        irq_en         = '0;
        mstatus_mie    = 1'b0;
        mtvec          = '0;
        exception_flag = 1'b0;
        mret           = 1'b0;
        pend_clr       = 1'b0;
        pend_clr_idx   = '0;
        trap_ack       = 1'b0;
        tick;
        tick;
        chk("rst_req",     32'(trap_req), 32'd0);
        chk("rst_cause",   trap_cause, 32'd0);
        chk("rst_pc",      trap_pc, 32'd0);
        chk("rst_mode",    32'(mode), 32'd3);
        chk("rst_pending", 32'(pending), 32'd0);

        // Two level sources, vectored mtvec: highest index wins.
        reset_in    = 1'b0;
        mstatus_mie = 1'b1;
        irq_en      = 16'h08A8;
        irq_src     = 16'h0880;
        mtvec       = 32'h0000_1001;
        tick;
        chk("lvl_pending", 32'(pending), 32'h0880);
        chk("lvl_req_lat", 32'(trap_req), 32'd0);
        tick;
        chk("lvl_req",   32'(trap_req), 32'd1);
        chk("lvl_cause", trap_cause, 32'h8000_000B);
        chk("lvl_pc",    trap_pc, 32'h0000_102C);
        irq_src = '0;
        tick;
        chk("hold_req",   32'(trap_req), 32'd1);
        chk("hold_cause", trap_cause, 32'h8000_000B);
        chk("hold_pc",    trap_pc, 32'h0000_102C);
        trap_ack = 1'b1;
        tick;
        trap_ack = 1'b0;
        chk("ack_req",  32'(trap_req), 32'd0);
        chk("ack_mode", 32'(mode), 32'd3);

        // Edge pulse on src 3 while ACTIVE is held until after mret.
        irq_src = 16'h0008;
        tick;
        irq_src = '0;
        tick;
        tick;
        chk("edge_pend",   32'(pending), 32'h0008);
        chk("edge_no_req", 32'(trap_req), 32'd0);
        mret = 1'b1;
        tick;
        mret = 1'b0;
        chk("mret_req",  32'(trap_req), 32'd0);
        chk("mret_mode", 32'(mode), 32'd3);
        tick;
        chk("edge_req",   32'(trap_req), 32'd1);
        chk("edge_cause", trap_cause, 32'h8000_0003);
        chk("edge_pc",    trap_pc, 32'h0000_100C);
        trap_ack = 1'b1;
        tick;
        trap_ack = 1'b0;
        chk("edge_ack_clr", 32'(pending), 32'd0);
        mret = 1'b1;
        tick;
        // Second mret in IDLE drops to U (mpp was set to U by the first).
        tick;
        mret = 1'b0;
        chk("to_user", 32'(mode), 32'd0);

        // User mode ignores mstatus_mie; direct mtvec.
        mstatus_mie = 1'b0;
        mtvec       = 32'h0000_2000;
        irq_src     = 16'h0080;
        tick;
        tick;
        chk("u_req",   32'(trap_req), 32'd1);
        chk("u_pc",    trap_pc, 32'h0000_2000);
        chk("u_cause", trap_cause, 32'h8000_0007);
        trap_ack = 1'b1;
        irq_src  = '0;
        tick;
        trap_ack = 1'b0;
        chk("u_ack_mode", 32'(mode), 32'd3);
        mret = 1'b1;
        tick;
        mret = 1'b0;
        chk("u_mret_mode", 32'(mode), 32'd0);
        tick;
        chk("u_idle_req", 32'(trap_req), 32'd0);

        // Exception in the cycle the interrupt becomes eligible.
        mstatus_mie = 1'b1;
        irq_src     = 16'h0080;
        tick;
        exception_flag = 1'b1;
        tick;
        exception_flag = 1'b0;
        chk("exc_req",  32'(trap_req), 32'd0);
        chk("exc_mode", 32'(mode), 32'd3);
        tick;
        chk("exc_active_req", 32'(trap_req), 32'd0);
        mret = 1'b1;
        tick;
        mret = 1'b0;
        chk("exc_mret_req",  32'(trap_req), 32'd0);
        chk("exc_mret_mode", 32'(mode), 32'd0);
        tick;
        chk("exc_after_req",   32'(trap_req), 32'd1);
        chk("exc_after_cause", trap_cause, 32'h8000_0007);

        // Reset in the middle of a handshake.
        reset_in = 1'b1;
        tick;
        chk("mid_rst_req",   32'(trap_req), 32'd0);
        chk("mid_rst_pend",  32'(pending), 32'd0);
        chk("mid_rst_mode",  32'(mode), 32'd3);
        chk("mid_rst_cause", trap_cause, 32'd0);
        reset_in = 1'b0;
        irq_src  = '0;
        irq_en   = '0;

        // Set beats clear on edge src 5; out-of-range index ignored.
        irq_src = 16'h0020;
        tick;
        pend_clr     = 1'b1;
        pend_clr_idx = 5'd5;
        tick;
        pend_clr = 1'b0;
        chk("set_wins", 32'(pending), 32'h0020);
        pend_clr     = 1'b1;
        pend_clr_idx = 5'd21;
        tick;
        chk("clr_oob", 32'(pending), 32'h0020);
        pend_clr_idx = 5'd5;
        tick;
        pend_clr = 1'b0;
        chk("clr_edge", 32'(pending), 32'd0);
        irq_src = 16'h00A0;
        tick;
        pend_clr     = 1'b1;
        pend_clr_idx = 5'd7;
        tick;
        pend_clr = 1'b0;
        chk("clr_level", 32'(pending), 32'h0080);
        chk("no_req_dis", 32'(trap_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
